peri_bus_master: RTL and testbench
==================================

// Module: peri_bus_master
// PURPOSE
//  Initiator side of the core's peripheral bus (peri_w/peri_r/peri_addr/peri_wdat/peri_rdat/peri_ack).
//  Accepts single word load/store requests from the core LSU and runs one bus cycle per request.
//  Each bus cycle is held until the external responder (peri) acks it or a timeout expires.
//  Returns read data or an error to the LSU. Sits inside top, between core_u and the peri_* ports.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles a strobe may stay high without ack before the access aborts (>=2)
//  CNT_W           9    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk        in   1   core clock
//  cpurst     in   1   reset: synchronous, active-high
//  req_valid  in   1   LSU request valid
//  req_ready  out  1   block can accept a request (state IDLE)
//  req_we     in   1   1=store, 0=load
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data
//  rsp_valid  out  1   response valid; held until rsp_ready
//  rsp_ready  in   1   LSU takes response
//  rsp_rdata  out  32  load data (0 for stores and errors)
//  rsp_err    out  1   1=misaligned or timeout
//  peri_w     out  1   write strobe (level)
//  peri_r     out  1   read strobe (level)
//  peri_addr  out  32  bus address
//  peri_wdat  out  32  bus write data
//  peri_rdat  in   32  bus read data, valid when peri_ack=1
//  peri_ack   in   1   responder completion pulse
// BEHAVIOUR
//  Reset (cpurst=1 at posedge): state=IDLE; all outputs 0 except req_ready=1; counter=0. Applies mid-access:
//   strobes drop at that edge and the in-flight request is discarded with no response.
//  All outputs registered except req_ready = (state==IDLE).
//  IDLE: on req_valid&req_ready at edge N:
//   - req_addr[1:0]!=0 -> RESP with rsp_err=1, rsp_rdata=0; no bus cycle.
//   - else -> ACCESS: peri_addr/peri_wdat latched; peri_w=req_we, peri_r=~req_we high from cycle N+1; cnt=0.
//  ACCESS: addr/wdat/strobe stable every cycle. peri_w and peri_r never both 1.
//   - peri_ack=1 in cycle M -> at edge M strobes drop, rsp_valid=1, rsp_err=0,
//     rsp_rdata = peri_rdat for loads, 0 for stores. Min latency: ack in first strobe cycle -> rsp_valid at N+2.
//   - no ack and cnt==TIMEOUT_CYCLES-1 -> strobes drop, rsp_err=1, rsp_rdata=0; else cnt++.
//   - ack and timeout in the same cycle: ack wins (normal completion).
//  RESP: rsp_valid/rsp_rdata/rsp_err stable until rsp_ready=1; at that edge clear all three -> IDLE.
//   Next request is accepted no earlier than the cycle after that edge. Strobe low >=1 cycle between accesses.
//  peri_ack while not in ACCESS (late ack after timeout) is ignored; no state change.
//  peri_addr/peri_wdat keep their last value when idle; stores' peri_wdat=0 never forced.
// TESTING
//  1 Load 0x9000_0010, peri acks in 1st strobe cycle with rdat=0xDEADBEEF -> peri_r 1 cycle, rsp_valid at N+2,
//    rsp_rdata=0xDEADBEEF, rsp_err=0.
//  2 Store 0x9000_0004 wdata=0x12345678, ack after 5 cycles -> peri_w high 5 cycles with stable addr/wdat,
//    rsp_rdata=0, rsp_err=0.
//  3 Load 0x9000_0002 -> no peri_r pulse; rsp_err=1 at N+1.
//  4 No ack, TIMEOUT_CYCLES=8 -> strobe high exactly 8 cycles then rsp_err=1; ack injected 2 cycles later ignored.
//  5 Ack coincident with last timeout cycle -> rsp_err=0, data returned. rsp_ready low 4 cycles -> rsp held,
//    req_ready=0 until release.
//  6 cpurst asserted mid-ACCESS -> strobes 0 after that edge, no rsp_valid; next load completes normally.

Source files
------------

// File: rtl/peri_bus_master.sv
// Peripheral bus initiator: runs one single-word bus cycle per LSU request, holding the strobe
// until the responder acks or a timeout expires, then returns data or an error to the LSU.
module peri_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        peri_w,
    output logic        peri_r,
    output logic [31:0] peri_addr,
    output logic [31:0] peri_wdat,
    input  logic [31:0] peri_rdat,
    input  logic        peri_ack
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               peri_w_q, peri_w_d;
    logic               peri_r_q, peri_r_d;
    logic [31:0]        peri_addr_q, peri_addr_d;
    logic [31:0]        peri_wdat_q, peri_wdat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    always_ff @(posedge clk) begin
        if (cpurst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            peri_w_q    <= 1'b0;
            peri_r_q    <= 1'b0;
            peri_addr_q <= '0;
            peri_wdat_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            peri_w_q    <= peri_w_d;
            peri_r_q    <= peri_r_d;
            peri_addr_q <= peri_addr_d;
            peri_wdat_q <= peri_wdat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        peri_w_d    = peri_w_q;
        peri_r_d    = peri_r_q;
        peri_addr_d = peri_addr_q;
        peri_wdat_d = peri_wdat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_addr[1:0] != 2'b00) begin
                        // Misaligned: answer straight away without touching the bus.
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d     = StAccess;
                        peri_addr_d = req_addr;
                        peri_wdat_d = req_wdata;
                        peri_w_d    = req_we;
                        peri_r_d    = ~req_we;
                        cnt_d       = '0;
                    end
                end
            end
            StAccess: begin
                // Ack is tested first so a coincident timeout still completes normally.
                if (peri_ack) begin
                    state_d     = StResp;
                    peri_w_d    = 1'b0;
                    peri_r_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = peri_r_q ? peri_rdat : '0;
                end else if (cnt_q == CntLast) begin
                    state_d     = StResp;
                    peri_w_d    = 1'b0;
                    peri_r_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = rsp_valid_q;
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
        peri_w    = peri_w_q;
        peri_r    = peri_r_q;
        peri_addr = peri_addr_q;
        peri_wdat = peri_wdat_q;
    end

endmodule

// File: tb/tb_peri_bus_master.sv
// Directed bench for peri_bus_master with a short timeout so the abort path is reachable.
module tb_peri_bus_master;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        peri_w, peri_r, peri_ack;
    logic [31:0] peri_addr, peri_wdat, peri_rdat;

    int tests = 0;
    int fails = 0;

    peri_bus_master #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk       (clk),
        .cpurst    (cpurst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .peri_w    (peri_w),
        .peri_r    (peri_r),
        .peri_addr (peri_addr),
        .peri_wdat (peri_wdat),
        .peri_rdat (peri_rdat),
        .peri_ack  (peri_ack)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        cpurst = 1'b1;
        tick();
        tick();
        cpurst = 1'b0;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        tests++; if ({rsp_valid, rsp_err, peri_w, peri_r} !== 4'b0000) begin
            fails++; $display("FAIL reset_ctrl got %b exp 0000", {rsp_valid, rsp_err, peri_w, peri_r});
        end
        tests++; if ({rsp_rdata, peri_addr, peri_wdat} !== 96'h0) begin
            fails++; $display("FAIL reset_data got %h exp 0", {rsp_rdata, peri_addr, peri_wdat});
        end
    endtask

    task automatic test_load_fast();
        issue(1'b0, 32'h9000_0010, 32'h0);
        tests++; if ({peri_r, peri_w} !== 2'b10) begin fails++; $display("FAIL t1_strobe got %b exp 10", {peri_r, peri_w}); end
        tests++; if (peri_addr !== 32'h9000_0010) begin fails++; $display("FAIL t1_addr got %h exp 90000010", peri_addr); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL t1_req_ready got %b exp 0", req_ready); end
        peri_ack  = 1'b1;
        peri_rdat = 32'hDEAD_BEEF;
        tick();
        peri_ack  = 1'b0;
        tests++; if (peri_r !== 1'b0) begin fails++; $display("FAIL t1_strobe_drop got %b exp 0", peri_r); end
        tests++; if ({rsp_valid, rsp_err} !== 2'b10) begin fails++; $display("FAIL t1_rsp got %b exp 10", {rsp_valid, rsp_err}); end
        tests++; if (rsp_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL t1_rdata got %h exp deadbeef", rsp_rdata); end
        release_rsp();
        tests++; if ({rsp_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL t1_release got %b exp 01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_store_slow();
        int bad = 0;
        issue(1'b1, 32'h9000_0004, 32'h1234_5678);
        req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if ({peri_w, peri_r} !== 2'b10 || peri_addr !== 32'h9000_0004 || peri_wdat !== 32'h1234_5678
                || rsp_valid !== 1'b0) bad++;
            if (i == 4) begin
                peri_ack  = 1'b1;
                peri_rdat = 32'hFFFF_FFFF;
            end
            tick();
        end
        peri_ack = 1'b0;
        tests++; if (bad !== 0) begin fails++; $display("FAIL t2_hold got %0d bad cycles exp 0", bad); end
        tests++; if (peri_w !== 1'b0) begin fails++; $display("FAIL t2_strobe_drop got %b exp 0", peri_w); end
        tests++; if ({rsp_valid, rsp_err} !== 2'b10) begin fails++; $display("FAIL t2_rsp got %b exp 10", {rsp_valid, rsp_err}); end
        tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL t2_rdata got %h exp 0", rsp_rdata); end
        tests++; if (peri_wdat !== 32'h1234_5678) begin fails++; $display("FAIL t2_wdat_keep got %h exp 12345678", peri_wdat); end
        release_rsp();
    endtask

    task automatic test_misaligned();
        issue(1'b0, 32'h9000_0002, 32'h0);
        tests++; if ({peri_r, peri_w} !== 2'b00) begin fails++; $display("FAIL t3_no_strobe got %b exp 00", {peri_r, peri_w}); end
        tests++; if ({rsp_valid, rsp_err} !== 2'b11) begin fails++; $display("FAIL t3_rsp got %b exp 11", {rsp_valid, rsp_err}); end
        tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL t3_rdata got %h exp 0", rsp_rdata); end
        release_rsp();
    endtask

    task automatic test_timeout();
        int high = 0;
        issue(1'b0, 32'h9000_0008, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (peri_r === 1'b1) high++;
            tick();
        end
        tests++; if (high !== 8) begin fails++; $display("FAIL t4_strobe_len got %0d exp 8", high); end
        tests++; if (peri_r !== 1'b0) begin fails++; $display("FAIL t4_strobe_drop got %b exp 0", peri_r); end
        tests++; if ({rsp_valid, rsp_err} !== 2'b11) begin fails++; $display("FAIL t4_rsp got %b exp 11", {rsp_valid, rsp_err}); end
        tick();
        tick();
        peri_ack  = 1'b1;
        peri_rdat = 32'hCAFE_0001;
        tick();
        peri_ack  = 1'b0;
        tests++; if ({rsp_valid, rsp_err, peri_r} !== 3'b110 || rsp_rdata !== 32'h0) begin
            fails++; $display("FAIL t4_late_ack got %b/%h exp 110/0", {rsp_valid, rsp_err, peri_r}, rsp_rdata);
        end
        release_rsp();
        peri_ack = 1'b1;
        tick();
        peri_ack = 1'b0;
        tests++; if ({rsp_valid, req_ready, peri_r, peri_w} !== 4'b0100) begin
            fails++; $display("FAIL t4_idle_ack got %b exp 0100", {rsp_valid, req_ready, peri_r, peri_w});
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        issue(1'b0, 32'h9000_000C, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                peri_ack  = 1'b1;
                peri_rdat = 32'hA5A5_5A5A;
            end
            tick();
        end
        peri_ack = 1'b0;
        tests++; if ({rsp_valid, rsp_err} !== 2'b10) begin fails++; $display("FAIL t5_ack_wins got %b exp 10", {rsp_valid, rsp_err}); end
        tests++; if (rsp_rdata !== 32'hA5A5_5A5A) begin fails++; $display("FAIL t5_rdata got %h exp a5a55a5a", rsp_rdata); end
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h9000_0020;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_5A5A || rsp_err !== 1'b0
                || req_ready !== 1'b0 || peri_r !== 1'b0) bad++;
            tick();
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL t5_hold got %0d bad cycles exp 0", bad); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests++; if ({rsp_valid, req_ready, peri_r} !== 3'b010) begin
            fails++; $display("FAIL t5_gap got %b exp 010", {rsp_valid, req_ready, peri_r});
        end
        tick();
        req_valid = 1'b0;
        tests++; if (peri_r !== 1'b1 || peri_addr !== 32'h9000_0020) begin
            fails++; $display("FAIL t5_next got %b/%h exp 1/90000020", peri_r, peri_addr);
        end
        peri_ack  = 1'b1;
        peri_rdat = 32'h0BAD_F00D;
        tick();
        peri_ack  = 1'b0;
        tests++; if (rsp_rdata !== 32'h0BAD_F00D) begin fails++; $display("FAIL t5_next_rdata got %h exp 0badf00d", rsp_rdata); end
        release_rsp();
    endtask

    task automatic test_reset_mid_access();
        int bad = 0;
        issue(1'b0, 32'h9000_0030, 32'h0);
        tick();
        tick();
        cpurst = 1'b1;
        tick();
        cpurst = 1'b0;
        tests++; if ({peri_r, peri_w, rsp_valid, req_ready} !== 4'b0001) begin
            fails++; $display("FAIL t6_reset got %b exp 0001", {peri_r, peri_w, rsp_valid, req_ready});
        end
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid !== 1'b0 || peri_r !== 1'b0) bad++;
            tick();
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL t6_quiet got %0d bad cycles exp 0", bad); end
        issue(1'b0, 32'h9000_0040, 32'h0);
        tests++; if (peri_r !== 1'b1) begin fails++; $display("FAIL t6_next_strobe got %b exp 1", peri_r); end
        peri_ack  = 1'b1;
        peri_rdat = 32'h7654_3210;
        tick();
        peri_ack  = 1'b0;
        tests++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h7654_3210) begin
            fails++; $display("FAIL t6_next_rsp got %b/%h exp 10/76543210", {rsp_valid, rsp_err}, rsp_rdata);
        end
        release_rsp();
    endtask

    initial begin
        cpurst    = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        peri_rdat = '0;
        peri_ack  = 1'b0;
        test_reset();
        test_load_fast();
        test_store_slow();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
